// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the config register file between SPI (S) and fabric (L) requesters.
// Optional L-side write protection above PROT_BASE: define REG_WRITE_PROTECT_EN.
module reg_bus_arbiter #(
  parameter int                 ADDR_W    = 6,
  parameter int                 DATA_W    = 16,
  parameter logic [ADDR_W-1:0]  PROT_BASE = 6'h30
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_rsp_valid,
  output logic [DATA_W-1:0] s_rsp_data,
  output logic              s_rsp_err,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_rsp_valid,
  output logic [DATA_W-1:0] l_rsp_data,
  output logic              l_rsp_err,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata
);

`ifdef REG_WRITE_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;  // 0 = S, 1 = L
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic                prot_q, prot_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                reg_we_q, reg_we_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                grant_s, grant_l, s_hs, l_hs;
  logic [DATA_W-1:0]   rsp_data;

  always_comb begin
    grant_s = s_valid && (!l_valid || last_grant_q);
    grant_l = l_valid && (!s_valid || !last_grant_q);
    s_ready = (state_q == IDLE) && !sys_rst && grant_s;
    l_ready = (state_q == IDLE) && !sys_rst && grant_l;
    s_hs    = s_ready;
    l_hs    = l_ready;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    prot_d       = prot_q;
    rsp_valid_d  = 1'b0;
    reg_we_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;

    case (state_q)
      IDLE: begin
        if (s_hs || l_hs) begin
          owner_d      = l_hs;
          last_grant_d = l_hs;
          we_d         = l_hs ? l_we    : s_we;
          reg_addr_d   = l_hs ? l_addr  : s_addr;
          reg_wdata_d  = l_hs ? l_wdata : s_wdata;
          // protection only ever blocks fabric writes; SPI keeps full access
          prot_d       = PROT_EN && l_hs && l_we && (l_addr >= PROT_BASE);
          reg_we_d     = we_d && !prot_d;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      prot_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      prot_q       <= prot_d;
      rsp_valid_q  <= rsp_valid_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
    end
  end

  // read data arrives from the register file during RESP, so it is muxed in rather than flopped
  always_comb begin
    rsp_data = '0;
    if (rsp_valid_q) begin
      if (!we_q)       rsp_data = reg_rdata;
      else if (!prot_q) rsp_data = reg_wdata_q;
    end
  end

  assign reg_we      = reg_we_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign s_rsp_valid = rsp_valid_q && !owner_q && !sys_rst;
  assign l_rsp_valid = rsp_valid_q &&  owner_q && !sys_rst;
  assign s_rsp_data  = s_rsp_valid ? rsp_data : '0;
  assign l_rsp_data  = l_rsp_valid ? rsp_data : '0;
  assign s_rsp_err   = s_rsp_valid && prot_q;
  assign l_rsp_err   = l_rsp_valid && prot_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with a 64x16 register file model (1-cycle read latency).
module tb_reg_bus_arbiter;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        s_valid = 1'b0, s_we = 1'b0, l_valid = 1'b0, l_we = 1'b0;
  logic [5:0]  s_addr = '0, l_addr = '0;
  logic [15:0] s_wdata = '0, l_wdata = '0;
  logic        s_ready, s_rsp_valid, s_rsp_err, l_ready, l_rsp_valid, l_rsp_err, reg_we;
  logic [15:0] s_rsp_data, l_rsp_data, reg_wdata, reg_rdata;
  logic [5:0]  reg_addr;
  logic [15:0] mem [64];
  int          n_tests = 0, n_fail = 0;
  logic        exp_s;

  always #5 sys_clk = ~sys_clk;

  reg_bus_arbiter dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rsp_valid(s_rsp_valid), .s_rsp_data(s_rsp_data), .s_rsp_err(s_rsp_err),
    .l_valid(l_valid), .l_ready(l_ready), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data), .l_rsp_err(l_rsp_err),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
    reg_rdata = '0;
  end

  always @(posedge sys_clk) begin
    reg_rdata <= mem[reg_addr];
    if (reg_we) mem[reg_addr] <= reg_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset held with both requesters asking
    s_valid = 1'b1; l_valid = 1'b1;
    @(posedge sys_clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_l_ready", 32'(l_ready), 0);
      chk("rst_reg_we", 32'(reg_we), 0);
      chk("rst_reg_addr", 32'(reg_addr), 0);
      chk("rst_rsp", 32'({s_rsp_valid, l_rsp_valid, s_rsp_err, l_rsp_err}), 0);
      chk("rst_rsp_data", 32'({s_rsp_data, l_rsp_data}), 0);
    end
    step();
    sys_rst = 1'b0; s_valid = 1'b0; l_valid = 1'b0;

    // S write 0x01=0xAAAA, then read it back
    s_valid = 1'b1; s_we = 1'b1; s_addr = 6'h01; s_wdata = 16'hAAAA;
    @(negedge sys_clk); chk("wr_s_ready", 32'(s_ready), 1);
    step(); s_valid = 1'b0;
    @(negedge sys_clk);
    chk("wr_reg_we", 32'(reg_we), 1);
    chk("wr_reg_addr", 32'(reg_addr), 32'h01);
    chk("wr_reg_wdata", 32'(reg_wdata), 32'hAAAA);
    chk("wr_no_rsp_yet", 32'(s_rsp_valid), 0);
    @(negedge sys_clk);
    chk("wr_rsp_valid", 32'(s_rsp_valid), 1);
    chk("wr_rsp_data", 32'(s_rsp_data), 32'hAAAA);
    chk("wr_rsp_err", 32'(s_rsp_err), 0);
    chk("wr_reg_we_off", 32'(reg_we), 0);
    step();
    s_valid = 1'b1; s_we = 1'b0;
    @(negedge sys_clk); chk("rd_s_ready", 32'(s_ready), 1);
    step(); s_valid = 1'b0;
    @(negedge sys_clk); chk("rd_reg_we", 32'(reg_we), 0);
    @(negedge sys_clk);
    chk("rd_rsp_valid", 32'(s_rsp_valid), 1);
    chk("rd_rsp_data", 32'(s_rsp_data), 32'hAAAA);
    chk("rd_l_rsp_valid", 32'(l_rsp_valid), 0);
    step();

    // fresh reset so the first tie goes to S, then strict alternation
    sys_rst = 1'b1; step(); sys_rst = 1'b0;
    s_valid = 1'b1; s_we = 1'b1; s_addr = 6'h05; s_wdata = 16'h5555;
    l_valid = 1'b1; l_we = 1'b0; l_addr = 6'h05;
    for (int k = 0; k < 4; k++) begin
      exp_s = (k % 2 == 0);
      @(negedge sys_clk);
      chk("rr_s_ready", 32'(s_ready), 32'(exp_s));
      chk("rr_l_ready", 32'(l_ready), 32'(!exp_s));
      @(negedge sys_clk);
      chk("rr_reg_we", 32'(reg_we), 32'(exp_s));
      chk("rr_reg_addr", 32'(reg_addr), 32'h05);
      chk("rr_ready_busy", 32'({s_ready, l_ready}), 0);
      @(negedge sys_clk);
      chk("rr_s_rsp_valid", 32'(s_rsp_valid), 32'(exp_s));
      chk("rr_l_rsp_valid", 32'(l_rsp_valid), 32'(!exp_s));
      chk("rr_rsp_data", 32'(exp_s ? s_rsp_data : l_rsp_data), 32'h5555);
    end
    step(); s_valid = 1'b0; l_valid = 1'b0;

    // L alone, back to back reads of 0x00 and 0x07
    l_valid = 1'b1; l_we = 1'b0; l_addr = 6'h00;
    @(negedge sys_clk);
    chk("l_only_ready0", 32'(l_ready), 1);
    chk("l_only_s_ready", 32'(s_ready), 0);
    step(); l_addr = 6'h07;
    @(negedge sys_clk); chk("l_only_busy1", 32'(l_ready), 0);
    @(negedge sys_clk);
    chk("l_only_busy2", 32'(l_ready), 0);
    chk("l_only_rsp0", 32'(l_rsp_data), 32'h1000);
    chk("l_only_rsp0_v", 32'(l_rsp_valid), 1);
    chk("l_only_s_rsp0", 32'(s_rsp_valid), 0);
    @(negedge sys_clk); chk("l_only_ready3", 32'(l_ready), 1);
    step(); l_valid = 1'b0;
    @(negedge sys_clk); chk("l_only_addr7", 32'(reg_addr), 32'h07);
    @(negedge sys_clk);
    chk("l_only_rsp7", 32'(l_rsp_data), 32'h1007);
    chk("l_only_s_rsp7", 32'(s_rsp_valid), 0);
    step();

    // reset during RESP of an L read discards the response
    l_valid = 1'b1; l_addr = 6'h07;
    @(negedge sys_clk); chk("rstmid_l_ready", 32'(l_ready), 1);
    step(); l_valid = 1'b0;
    step(); sys_rst = 1'b1;
    @(negedge sys_clk); chk("rstmid_no_rsp", 32'(l_rsp_valid), 0);
    step(); sys_rst = 1'b0;
    s_valid = 1'b1; s_we = 1'b0; s_addr = 6'h01; l_valid = 1'b1; l_addr = 6'h00;
    @(negedge sys_clk);
    chk("rstmid_s_first", 32'(s_ready), 1);
    chk("rstmid_l_wait", 32'(l_ready), 0);
    step(); s_valid = 1'b0; l_valid = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("rstmid_s_rsp", 32'(s_rsp_data), 32'hAAAA);
    chk("rstmid_l_rsp", 32'(l_rsp_valid), 0);
    step();

    // L write into the protectable region
    l_valid = 1'b1; l_we = 1'b1; l_addr = 6'h30; l_wdata = 16'hFFFF;
    @(negedge sys_clk); chk("prot_l_ready", 32'(l_ready), 1);
    step(); l_valid = 1'b0;
`ifdef REG_WRITE_PROTECT_EN
    @(negedge sys_clk); chk("prot_reg_we", 32'(reg_we), 0);
    @(negedge sys_clk);
    chk("prot_rsp_valid", 32'(l_rsp_valid), 1);
    chk("prot_rsp_err", 32'(l_rsp_err), 1);
    chk("prot_rsp_data", 32'(l_rsp_data), 0);
    step();
    chk("prot_mem", 32'(mem[6'h30]), 32'h1030);
    s_valid = 1'b1; s_we = 1'b1; s_addr = 6'h30; s_wdata = 16'hFFFF;
    @(negedge sys_clk); chk("prot_s_ready", 32'(s_ready), 1);
    step(); s_valid = 1'b0;
    @(negedge sys_clk); chk("prot_s_reg_we", 32'(reg_we), 1);
    @(negedge sys_clk);
    chk("prot_s_err", 32'(s_rsp_err), 0);
    chk("prot_s_data", 32'(s_rsp_data), 32'hFFFF);
    step();
    chk("prot_s_mem", 32'(mem[6'h30]), 32'hFFFF);
`else
    @(negedge sys_clk); chk("noprot_reg_we", 32'(reg_we), 1);
    @(negedge sys_clk);
    chk("noprot_rsp_valid", 32'(l_rsp_valid), 1);
    chk("noprot_rsp_err", 32'(l_rsp_err), 0);
    chk("noprot_rsp_data", 32'(l_rsp_data), 32'hFFFF);
    step();
    chk("noprot_mem", 32'(mem[6'h30]), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
